// File: rtl/ahb_default_slave_err_pkg.sv
// ahb_pkg: AHB transfer/response encodings and default-slave state type
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } ds_state_e;

    function automatic logic is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_err_log.sv
// ahb_err_log: first-error address/direction capture and saturating error counter
module ahb_err_log #(
    parameter int ADDR_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 cap_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic                 write_i,
    input  logic                 inc_i,
    output logic                 valid_o,
    output logic [ADDR_W-1:0]    addr_o,
    output logic                 write_o,
    output logic [ERR_CNT_W-1:0] cnt_o
);
    logic                 valid_q, valid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 write_q, write_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    // clear first, then apply any coincident capture/increment on top of it
    always_comb begin
        valid_d = clr_i ? 1'b0 : valid_q;
        addr_d  = clr_i ? '0 : addr_q;
        write_d = clr_i ? 1'b0 : write_q;
        cnt_d   = clr_i ? '0 : cnt_q;
        if (cap_i && !valid_d) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            write_d = write_i;
        end
        if (inc_i && !(&cnt_d))
            cnt_d = cnt_d + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign write_o = write_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/ahb_default_slave_err.sv
// ahb_default_slave_err: AHB default slave answering unmapped accesses with
// optional wait states and a two-cycle ERROR, plus first-error debug logging.
module ahb_default_slave_err
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int ERR_CNT_W   = 8,
    parameter int OKAY_MODE   = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSELDefault,
    input  logic                 HREADYIn,
    input  logic [1:0]           HTRANS,
    input  logic [ADDR_W-1:0]    HADDR,
    input  logic                 HWRITE,
    input  logic                 ErrClr,
    output logic                 HREADYOut,
    output logic [1:0]           HRESP,
    output logic                 ErrValid,
    output logic [ADDR_W-1:0]    ErrAddr,
    output logic                 ErrWrite,
    output logic [ERR_CNT_W-1:0] ErrCount
);
    localparam logic [3:0] WLOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    ds_state_e  state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       hready_q;
    logic [1:0] hresp_q;
    logic       acc, take;

    assign acc  = HSELDefault & HREADYIn & is_active(HTRANS) & (OKAY_MODE == 0);
    assign take = acc & ((state_q == S_IDLE) | (state_q == S_ERR2));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = take ? ((WAIT_CYCLES > 0) ? S_WAIT : S_ERR1) : S_IDLE;
                wait_d  = take ? WLOAD : wait_q;
            end
            S_WAIT: begin
                state_d = (wait_q == 4'd0) ? S_ERR1 : S_WAIT;
                wait_d  = (wait_q == 4'd0) ? wait_q : wait_q - 4'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs are decoded from the next state so they are registered with it
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q  <= S_IDLE;
            wait_q   <= 4'd0;
            hready_q <= 1'b1;
            hresp_q  <= HR_OKAY;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            hready_q <= (state_d == S_IDLE) || (state_d == S_ERR2);
            hresp_q  <= ((state_d == S_ERR1) || (state_d == S_ERR2)) ? HR_ERROR : HR_OKAY;
        end
    end

    assign HREADYOut = hready_q;
    assign HRESP     = hresp_q;

    ahb_err_log #(
        .ADDR_W    (ADDR_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_log (
        .clk     (HCLK),
        .rst_n   (HRESET),
        .clr_i   (ErrClr),
        .cap_i   (take),
        .addr_i  (HADDR),
        .write_i (HWRITE),
        .inc_i   (state_q == S_ERR1),
        .valid_o (ErrValid),
        .addr_o  (ErrAddr),
        .write_o (ErrWrite),
        .cnt_o   (ErrCount)
    );

endmodule

// File: tb/tb_ahb_default_slave_err.sv
// tb_ahb_default_slave_err: directed checks of three default-slave configurations
module tb_ahb_default_slave_err;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel0, sel3, selk;
    logic        hready_in;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic        clr;

    logic        rdy0, rdy3, rdyk;
    logic [1:0]  rsp0, rsp3, rspk;
    logic        val0, val3, valk;
    logic [31:0] ea0, ea3, eak;
    logic        ew0, ew3, ewk;
    logic [7:0]  cnt0, cntk;
    logic [1:0]  cnt3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ahb_default_slave_err #(.WAIT_CYCLES(0)) d0 (
        .HCLK(clk), .HRESET(rst_n), .HSELDefault(sel0), .HREADYIn(hready_in),
        .HTRANS(trans), .HADDR(addr), .HWRITE(wr), .ErrClr(clr),
        .HREADYOut(rdy0), .HRESP(rsp0), .ErrValid(val0), .ErrAddr(ea0),
        .ErrWrite(ew0), .ErrCount(cnt0)
    );

    ahb_default_slave_err #(.WAIT_CYCLES(3), .ERR_CNT_W(2)) d3 (
        .HCLK(clk), .HRESET(rst_n), .HSELDefault(sel3), .HREADYIn(hready_in),
        .HTRANS(trans), .HADDR(addr), .HWRITE(wr), .ErrClr(clr),
        .HREADYOut(rdy3), .HRESP(rsp3), .ErrValid(val3), .ErrAddr(ea3),
        .ErrWrite(ew3), .ErrCount(cnt3)
    );

    ahb_default_slave_err #(.OKAY_MODE(1)) dk (
        .HCLK(clk), .HRESET(rst_n), .HSELDefault(selk), .HREADYIn(hready_in),
        .HTRANS(trans), .HADDR(addr), .HWRITE(wr), .ErrClr(clr),
        .HREADYOut(rdyk), .HRESP(rspk), .ErrValid(valk), .ErrAddr(eak),
        .ErrWrite(ewk), .ErrCount(cntk)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // HREADYOut/HRESP pair packed as {ready, resp}
    task automatic rr0(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, rdy0, rsp0}, {29'd0, exp});
    endtask

    task automatic rr3(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, rdy3, rsp3}, {29'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; sel0 = 0; sel3 = 0; selk = 0; hready_in = 1;
        trans = 2'b00; addr = 32'h0; wr = 0; clr = 0;
        #12;
        rr0("rst_resp0", 3'b100);
        rr3("rst_resp3", 3'b100);
        chk("rst_valid0", {31'd0, val0}, 0);
        chk("rst_addr0", ea0, 0);
        chk("rst_cnt0", {24'd0, cnt0}, 0);
        rst_n = 1'b1;
        tick();

        sel0 = 1; trans = 2'b00;
        tick();
        rr0("idle_okay", 3'b100);
        trans = 2'b01;
        tick();
        rr0("busy_okay", 3'b100);
        chk("busy_cnt", {24'd0, cnt0}, 0);
        chk("busy_valid", {31'd0, val0}, 0);

        trans = 2'b10; addr = 32'h4000_0010; wr = 1;
        tick();
        rr0("w0_err1", 3'b001);
        chk("w0_valid", {31'd0, val0}, 1);
        chk("w0_addr", ea0, 32'h4000_0010);
        chk("w0_write", {31'd0, ew0}, 1);
        chk("w0_cnt_err1", {24'd0, cnt0}, 0);
        trans = 2'b00;
        tick();
        rr0("w0_err2", 3'b101);
        chk("w0_cnt", {24'd0, cnt0}, 1);
        tick();
        rr0("w0_idle", 3'b100);

        clr = 1;
        tick();
        clr = 0;
        chk("clr_valid", {31'd0, val0}, 0);
        chk("clr_addr", ea0, 0);
        chk("clr_cnt", {24'd0, cnt0}, 0);

        trans = 2'b10; addr = 32'h0000_0100; wr = 0;
        tick();
        rr0("b2b_err1a", 3'b001);
        chk("b2b_addr_a", ea0, 32'h0000_0100);
        chk("b2b_write_a", {31'd0, ew0}, 0);
        hready_in = 0; trans = 2'b11; addr = 32'h0000_0200; wr = 1;
        tick();
        rr0("b2b_err2a", 3'b101);
        chk("b2b_cnt_a", {24'd0, cnt0}, 1);
        hready_in = 1;
        tick();
        rr0("b2b_err1b", 3'b001);
        chk("b2b_addr_hold", ea0, 32'h0000_0100);
        trans = 2'b00;
        tick();
        rr0("b2b_err2b", 3'b101);
        chk("b2b_cnt_b", {24'd0, cnt0}, 2);
        tick();
        rr0("b2b_idle", 3'b100);

        clr = 1; trans = 2'b10; addr = 32'h0000_0300; wr = 1;
        tick();
        clr = 0; trans = 2'b00;
        chk("clracc_valid", {31'd0, val0}, 1);
        chk("clracc_addr", ea0, 32'h0000_0300);
        chk("clracc_write", {31'd0, ew0}, 1);
        chk("clracc_cnt0", {24'd0, cnt0}, 0);
        tick();
        chk("clracc_cnt1", {24'd0, cnt0}, 1);
        tick();

        sel0 = 0; sel3 = 1; trans = 2'b10; addr = 32'h0000_0500; wr = 0;
        tick();
        trans = 2'b00;
        rr3("ws_wait1", 3'b000);
        chk("ws_valid", {31'd0, val3}, 1);
        chk("ws_addr", ea3, 32'h0000_0500);
        tick();
        rr3("ws_wait2", 3'b000);
        tick();
        rr3("ws_wait3", 3'b000);
        tick();
        rr3("ws_err1", 3'b001);
        chk("ws_cnt_err1", {30'd0, cnt3}, 0);
        tick();
        rr3("ws_err2", 3'b101);
        chk("ws_cnt", {30'd0, cnt3}, 1);
        tick();
        rr3("ws_idle", 3'b100);

        for (int i = 0; i < 4; i++) begin
            trans = 2'b10; addr = 32'h0000_0600 + i;
            tick();
            trans = 2'b00;
            repeat (4) tick();
            rr3("sat_err2", 3'b101);
            chk("sat_cnt", {30'd0, cnt3}, (i + 2 > 3) ? 3 : i + 2);
            tick();
        end
        chk("sat_addr_hold", ea3, 32'h0000_0500);

        sel3 = 0; sel0 = 1; trans = 2'b10; addr = 32'h0000_0700; wr = 1;
        tick();
        rr0("rst_mid_err1", 3'b001);
        trans = 2'b00;
        rst_n = 1'b0;
        #1;
        rr0("rst_mid_resp", 3'b100);
        chk("rst_mid_valid", {31'd0, val0}, 0);
        chk("rst_mid_addr", ea0, 0);
        chk("rst_mid_cnt", {24'd0, cnt0}, 0);
        chk("rst_mid_cnt3", {30'd0, cnt3}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rr0("rst_mid_after", 3'b100);

        sel0 = 0; selk = 1; trans = 2'b10; addr = 32'h0000_0800; wr = 1;
        tick();
        chk("okm_resp1", {29'd0, rdyk, rspk}, 32'b100);
        chk("okm_valid", {31'd0, valk}, 0);
        tick();
        trans = 2'b00;
        chk("okm_resp2", {29'd0, rdyk, rspk}, 32'b100);
        tick();
        chk("okm_cnt", {24'd0, cntk}, 0);
        chk("okm_addr", eak, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_default_slave_err.md
# ahb_default_slave_err

Parametrised default slave for the AHB interconnect, selected by the address decoder whenever an unmapped region is accessed. Generates zero-wait OKAY for IDLE/BUSY and a two-cycle ERROR response, optionally preceded by programmable wait states, for NONSEQ/SEQ transfers. Adds a first-error address/direction capture and a saturating error counter for debug visibility. Drives the S->M response mux alongside the mapped slaves.

## Interface
- ADDR_W, 32, HADDR width
- WAIT_CYCLES, 0, OKAY wait states inserted before the ERROR response (0..15)
- ERR_CNT_W, 8, error counter width
- OKAY_MODE, 0, 1 = respond OKAY zero-wait to every transfer (no ERROR); capture/counter inactive

- HCLK  in  1  system bus clock
- HRESET  in  1  reset, asynchronous, active-low
- HSELDefault  in  1  default-slave select from decoder
- HREADYIn  in  1  bus HREADY (transfer-done) from S->M mux
- HTRANS  in  2  transfer type
- HADDR  in  ADDR_W  address
- HWRITE  in  1  transfer direction
- ErrClr  in  1  single-cycle clear of capture and counter
- HREADYOut  out  1  ready to S->M mux
- HRESP  out  2  response: 00 OKAY, 01 ERROR
- ErrValid  out  1  capture registers hold a first error
- ErrAddr  out  ADDR_W  HADDR of first errored transfer
- ErrWrite  out  1  HWRITE of first errored transfer
- ErrCount  out  ERR_CNT_W  number of ERROR responses, saturating

## Operation
- Accept: HSELDefault & HREADYIn at rising HCLK. HTRANS[1]=1 (NONSEQ/SEQ) is an error transfer; IDLE/BUSY is not.
- FSM states IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOut=1, HRESP=OKAY. Error transfer accepted -> WAIT if WAIT_CYCLES>0 (load wait counter), else ERR1. Otherwise stay.
  - WAIT: HREADYOut=0, HRESP=OKAY; counter decrements; at terminal count -> ERR1.
  - ERR1: HREADYOut=0, HRESP=ERROR; unconditionally -> ERR2.
  - ERR2: HREADYOut=1, HRESP=ERROR. Accept evaluated as in IDLE: new error transfer -> WAIT/ERR1, else IDLE.
- HREADYIn is ignored in WAIT/ERR1 (this slave owns the data phase).
- OKAY_MODE=1: FSM held in IDLE; HREADYOut=1, HRESP=OKAY always.
- Capture: on error-transfer accept with ErrValid=0, latch HADDR/HWRITE, set ErrValid. With ErrValid=1, no overwrite.
- Counter: increments on each ERR1 entry; holds at all-ones.
- ErrClr: clears ErrValid, ErrAddr, ErrWrite, ErrCount. Simultaneous ErrClr and accept/ERR1 entry: event applied after clear (ErrValid=1 with new address; ErrCount=1).

## Timing
- Reset (HRESET low, async): state IDLE, HREADYOut=1, HRESP=OKAY, ErrValid=0, ErrAddr=0, ErrWrite=0, ErrCount=0, wait counter 0.
- All outputs registered; no combinational input-to-output path.
- Address phase in cycle N: cycles N+1..N+WAIT_CYCLES WAIT; N+WAIT_CYCLES+1 ERR1; N+WAIT_CYCLES+2 ERR2 (transfer completes).
- ErrValid/ErrAddr visible from cycle N+1; ErrCount updated from cycle N+WAIT_CYCLES+2.
- Back-to-back: a transfer pipelined in ERR2 starts its response next cycle; no idle bubble.
- Reset assertion mid-response: immediate return to reset values; in-flight transfer dropped.

## Structure
- Shared package ahb_pkg: HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HRESP encodings (OKAY, ERROR), default-slave state enum.
- Sub-module ahb_err_log: capture registers, ErrValid, saturating counter, clear priority; FSM and wait counter stay in top.

## Test plan
- HSELDefault=1, HTRANS=IDLE then BUSY, HREADYIn=1 -> HREADYOut=1, HRESP=OKAY every cycle, ErrCount=0.
- WAIT_CYCLES=0, NONSEQ to 0x4000_0010 write -> next cycle HREADYOut=0/ERROR, then 1/ERROR; ErrAddr=0x4000_0010, ErrWrite=1, ErrCount=1.
- WAIT_CYCLES=3, NONSEQ read -> 3 cycles 0/OKAY, then 0/ERROR, 1/ERROR; completion 5 cycles after address phase.
- Two NONSEQs back-to-back (second accepted in ERR2) -> responses contiguous, ErrAddr holds first address, ErrCount=2; ERR_CNT_W=2 with 5 errors -> ErrCount=3.
- ErrClr coincident with a new NONSEQ accept -> ErrValid=1, ErrAddr=new address, ErrCount=1 after its ERR1.
- HRESET low during ERR1 -> HREADYOut=1, HRESP=OKAY, capture cleared; OKAY_MODE=1 NONSEQ -> 1/OKAY, no capture.
